// File: rtl/mul_issue_queue.sv
// mul_issue_queue
//   Reservation station in front of the 2-cycle multiply pipe. Renamed MUL ops wait
//   here until both source operands are available. Operands arrive either at dispatch
//   or by snooping the result buses. Each cycle the oldest ready op is issued through
//   registered outputs. The queue compacts on issue, so entry index is age order:
//   entry 0 is always the oldest.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   flush                     synchronous discard of all entries and the issue register
//   freeze_back               back-end stall: no dispatch, no issue, outputs hold
//   disp_*                    dispatch slot (valid/ready handshake, op fields, operand status)
//   cdb_valid/cdb_Pw/cdb_data NCDB packed result buses; bus i at [5i+:5] / [16i+:16]
//   valid_mul .. busB_mul     registered issue port to the multiplier
//   count                     number of occupied entries
module mul_issue_queue #(
    parameter int DEPTH = 4,
    parameter int NCDB  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         freeze_back,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [4:0]                   disp_Pw,
    input  logic [4:0]                   disp_tag_ROB,
    input  logic [4:0]                   disp_PsA,
    input  logic [4:0]                   disp_PsB,
    input  logic                         disp_rdyA,
    input  logic                         disp_rdyB,
    input  logic [15:0]                  disp_dataA,
    input  logic [15:0]                  disp_dataB,
    input  logic [NCDB-1:0]              cdb_valid,
    input  logic [5*NCDB-1:0]            cdb_Pw,
    input  logic [16*NCDB-1:0]           cdb_data,
    output logic                         valid_mul,
    output logic [4:0]                   Pw_mul,
    output logic [4:0]                   tag_ROB_mul,
    output logic [15:0]                  busA_mul,
    output logic [15:0]                  busB_mul,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic        vld;
        logic [4:0]  pw;
        logic [4:0]  rob;
        logic [4:0]  psa;
        logic [4:0]  psb;
        logic        rdya;
        logic        rdyb;
        logic [15:0] da;
        logic [15:0] db;
    } ent_t;

    ent_t          r_q   [DEPTH];
    ent_t          w_wk  [DEPTH];
    ent_t          w_nq  [DEPTH];
    ent_t          w_new;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_widx;
    logic [IW-1:0] w_sel;
    logic          w_found;
    logic          w_issue;
    logic          w_disp;

    // Applies result-bus wakeup to one entry. Buses are scanned from the highest
    // index down so the lowest matching bus is the one left standing. Operands that
    // are already ready are never overwritten, which keeps capture idempotent when a
    // bus holds its value across a freeze.
    function automatic ent_t wake(input ent_t e,
                                  input logic [NCDB-1:0]     v,
                                  input logic [5*NCDB-1:0]   p,
                                  input logic [16*NCDB-1:0]  d);
        wake = e;
        for (int i = NCDB - 1; i >= 0; i--) begin
            if (e.vld && !e.rdya && v[i] && p[5*i +: 5] == e.psa) begin
                wake.rdya = 1'b1;
                wake.da   = d[16*i +: 16];
            end
            if (e.vld && !e.rdyb && v[i] && p[5*i +: 5] == e.psb) begin
                wake.rdyb = 1'b1;
                wake.db   = d[16*i +: 16];
            end
        end
    endfunction

    assign disp_ready = (r_count != CW'(DEPTH)) && !freeze_back;
    assign count      = r_count;

    always_comb begin
        // Selection looks only at registered state, so a wakeup or dispatch in this
        // cycle cannot make an entry issue before the next cycle.
        w_found = 1'b0;
        w_sel   = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (r_q[j].vld && r_q[j].rdya && r_q[j].rdyb) begin
                w_found = 1'b1;
                w_sel   = IW'(j);
            end
        end
        w_issue = w_found && !freeze_back && !flush;
        w_disp  = disp_valid && disp_ready && !flush;
        // With a concurrent issue the shift happens first, so the new op lands one lower.
        w_widx  = r_count - CW'(w_issue);

        w_new      = '0;
        w_new.vld  = 1'b1;
        w_new.pw   = disp_Pw;
        w_new.rob  = disp_tag_ROB;
        w_new.psa  = disp_PsA;
        w_new.psb  = disp_PsB;
        w_new.rdya = disp_rdyA;
        w_new.rdyb = disp_rdyB;
        w_new.da   = disp_dataA;
        w_new.db   = disp_dataB;
        w_new      = wake(w_new, cdb_valid, cdb_Pw, cdb_data);

        for (int j = 0; j < DEPTH; j++) begin
            w_wk[j] = wake(r_q[j], cdb_valid, cdb_Pw, cdb_data);
            w_nq[j] = w_wk[j];
        end
        if (w_issue) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                if (j >= int'(w_sel)) w_nq[j] = w_wk[j+1];
            end
            w_nq[DEPTH-1] = '0;
        end
        if (w_disp) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (CW'(j) == w_widx) w_nq[j] = w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) r_q[j] <= '0;
            r_count     <= '0;
            valid_mul   <= 1'b0;
            Pw_mul      <= '0;
            tag_ROB_mul <= '0;
            busA_mul    <= '0;
            busB_mul    <= '0;
        end else if (flush) begin
            for (int j = 0; j < DEPTH; j++) r_q[j] <= '0;
            r_count     <= '0;
            valid_mul   <= 1'b0;
            Pw_mul      <= '0;
            tag_ROB_mul <= '0;
            busA_mul    <= '0;
            busB_mul    <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) r_q[j] <= w_nq[j];
            r_count <= r_count + CW'(w_disp) - CW'(w_issue);
            if (w_issue) begin
                valid_mul   <= 1'b1;
                Pw_mul      <= r_q[w_sel].pw;
                tag_ROB_mul <= r_q[w_sel].rob;
                busA_mul    <= r_q[w_sel].da;
                busB_mul    <= r_q[w_sel].db;
            end else if (!freeze_back) begin
                // The multiplier is frozen along with us, so a held valid is consumed once.
                valid_mul <= 1'b0;
            end
        end
    end

endmodule
